rvfpm_issue_ctrl: RTL and testbench

RVFPM_ISSUE_CTRL -- requirements
Module: rvfpm_issue_ctrl

---
 rtl/rvfpm_issue_pkg.sv | 48 ++++
 rtl/rvfpm_issue_ctrl_scoreboard.sv | 55 +++++
 rtl/rvfpm_issue_ctrl.sv | 125 ++++++++++++
 tb/tb_rvfpm_issue_ctrl.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rvfpm_issue_pkg.sv
// Shared constants, FSM state and scoreboard entry type for the rvfpm issue controller.
package rvfpm_issue_pkg;

    localparam int unsigned FREG_AW = 5;

    localparam logic [6:0] OP_FLW    = 7'b0000111;
    localparam logic [6:0] OP_FMADD  = 7'b1000011;
    localparam logic [6:0] OP_FMSUB  = 7'b1000111;
    localparam logic [6:0] OP_FNMSUB = 7'b1001011;
    localparam logic [6:0] OP_FNMADD = 7'b1001111;
    localparam logic [6:0] OP_FP     = 7'b1010011;

    localparam logic [6:0] F7_FMV_X_W = 7'b1110000;
    localparam logic [6:0] F7_FCMP    = 7'b1010000;
    localparam logic [6:0] F7_FCVT_W  = 7'b1100000;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HOLD,
        ST_DRAIN
    } issue_state_t;

    typedef struct packed {
        logic               valid;
        logic [FREG_AW-1:0] rd;
    } sb_entry_t;

    function automatic logic is_fused(input logic [6:0] op);
        return (op == OP_FMADD) || (op == OP_FMSUB) ||
               (op == OP_FNMSUB) || (op == OP_FNMADD);
    endfunction

    // FP ops whose result lands in an integer register do not claim an F destination.
    function automatic logic writes_f(input logic [31:0] ins);
        logic [6:0] op;
        logic [6:0] f7;
        op = ins[6:0];
        f7 = ins[31:25];
        if ((op == OP_FLW) || is_fused(op)) begin
            return 1'b1;
        end
        if (op == OP_FP) begin
            return !((f7 == F7_FMV_X_W) || (f7 == F7_FCMP) || (f7 == F7_FCVT_W));
        end
        return 1'b0;
    endfunction

endpackage

// File: rtl/rvfpm_issue_ctrl_scoreboard.sv
// In-flight F destination tracker: one shift slot per execute stage, plus source hazard compare.
module rvfpm_scoreboard
    import rvfpm_issue_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic               ck,
    input  logic               rst_n,
    input  logic               enable,
    input  logic               load,
    input  sb_entry_t          load_entry,
    input  logic [FREG_AW-1:0] rs1,
    input  logic [FREG_AW-1:0] rs2,
    input  logic [FREG_AW-1:0] rs3,
    input  logic               rs3_en,
    output logic               hit,
    output logic               any_valid
);

    sb_entry_t slot [DEPTH];

    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                slot[i] <= '0;
            end
        end else if (enable) begin
            slot[0] <= load ? load_entry : '0;
            for (int i = 1; i < DEPTH; i++) begin
                slot[i] <= slot[i-1];
            end
        end
    end

    // The last slot writes back at the end of this cycle, so it no longer blocks a reader.
    always_comb begin
        hit = 1'b0;
        for (int i = 0; i < DEPTH - 1; i++) begin
            if (slot[i].valid && ((slot[i].rd == rs1) || (slot[i].rd == rs2) ||
                                  (rs3_en && (slot[i].rd == rs3)))) begin
                hit = 1'b1;
            end
        end
    end

    always_comb begin
        any_valid = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (slot[i].valid) begin
                any_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rvfpm_issue_ctrl.sv
// Single-entry issue controller for the rvfpm pipeline with RAW hazard stall and flush drain.
// Optional hazard stall counter built only with RVFPM_ISSUE_STALL_CNT_EN defined.
module rvfpm_issue_ctrl
    import rvfpm_issue_pkg::*;
#(
    parameter int NUM_F_REGS      = 32,
    parameter int PIPELINE_STAGES = 4
) (
    input  logic        ck,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        flush,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic [31:0] instruction,
    output logic        issue_valid,
    output logic [31:0] issue_instr,
    output logic        busy,
    output logic [15:0] stall_cnt
);

    // state  | meaning
    // IDLE   | hold register empty
    // HOLD   | hold register full, waiting for hazard to clear
    // DRAIN  | flushed, waiting for in-flight results to retire

    localparam int RW = $clog2(NUM_F_REGS);

    issue_state_t       state;
    logic [31:0]        hold_instr;
    logic               sb_hit;
    logic               sb_any;
    logic               hazard;
    logic               issue;
    logic               ready_int;
    logic               accept;
    logic [FREG_AW-1:0] rs1;
    logic [FREG_AW-1:0] rs2;
    logic [FREG_AW-1:0] rs3;
    sb_entry_t          issue_entry;

    assign rs1               = FREG_AW'(hold_instr[15 +: RW]);
    assign rs2               = FREG_AW'(hold_instr[20 +: RW]);
    assign rs3               = FREG_AW'(hold_instr[27 +: RW]);
    assign issue_entry.valid = writes_f(hold_instr);
    assign issue_entry.rd    = FREG_AW'(hold_instr[7 +: RW]);

    assign hazard    = (state == ST_HOLD) && sb_hit;
    assign issue     = enable && (state == ST_HOLD) && !hazard && !flush;
    assign ready_int = enable && (state != ST_DRAIN) && ((state == ST_IDLE) || issue);
    assign accept    = instr_valid && ready_int;

    // Reset gating kept on the output only so rst_n never feeds a flop data path.
    assign instr_ready = ready_int && rst_n;
    assign issue_valid = issue;
    assign issue_instr = issue ? hold_instr : '0;
    assign busy        = (state != ST_IDLE) || sb_any;

    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            hold_instr <= '0;
        end else if (enable) begin
            if (flush) begin
                state      <= ST_DRAIN;
                hold_instr <= '0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (accept) begin
                            state      <= ST_HOLD;
                            hold_instr <= instruction;
                        end
                    end
                    ST_HOLD: begin
                        if (accept) begin
                            hold_instr <= instruction;
                        end else if (issue) begin
                            state      <= ST_IDLE;
                            hold_instr <= '0;
                        end
                    end
                    ST_DRAIN: begin
                        if (!sb_any) begin
                            state <= ST_IDLE;
                        end
                    end
                    default: begin
                        state      <= ST_IDLE;
                        hold_instr <= '0;
                    end
                endcase
            end
        end
    end

    rvfpm_scoreboard #(
        .DEPTH (PIPELINE_STAGES)
    ) u_scoreboard (
        .ck         (ck),
        .rst_n      (rst_n),
        .enable     (enable),
        .load       (issue),
        .load_entry (issue_entry),
        .rs1        (rs1),
        .rs2        (rs2),
        .rs3        (rs3),
        .rs3_en     (is_fused(hold_instr[6:0])),
        .hit        (sb_hit),
        .any_valid  (sb_any)
    );

`ifdef RVFPM_ISSUE_STALL_CNT_EN
    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (enable && hazard && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end
`else
    assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_rvfpm_issue_ctrl.sv
// Self-checking bench: timestamp-based issue/hazard model plus directed literal scenarios.
module tb_rvfpm_issue_ctrl;

    localparam int PS = 4;

    logic        ck = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b1;
    logic        flush = 1'b0;
    logic        instr_valid = 1'b0;
    logic        instr_ready;
    logic [31:0] instruction = '0;
    logic        issue_valid;
    logic [31:0] issue_instr;
    logic        busy;
    logic [15:0] stall_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    rvfpm_issue_ctrl #(
        .NUM_F_REGS      (32),
        .PIPELINE_STAGES (PS)
    ) dut (
        .ck          (ck),
        .rst_n       (rst_n),
        .enable      (enable),
        .flush       (flush),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instruction (instruction),
        .issue_valid (issue_valid),
        .issue_instr (issue_instr),
        .busy        (busy),
        .stall_cnt   (stall_cnt)
    );

    always #5 ck = ~ck;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] fp_r(input logic [6:0] f7, input logic [4:0] rs2,
                                         input logic [4:0] rs1, input logic [4:0] rd);
        return {f7, rs2, rs1, 3'b000, rd, 7'b1010011};
    endfunction

    function automatic logic [31:0] fmadd(input logic [4:0] rs3, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [4:0] rd);
        return {rs3, 2'b00, rs2, rs1, 3'b000, rd, 7'b1000011};
    endfunction

    // ---------------- reference model ----------------
    function automatic bit m_fused(input logic [31:0] ins);
        return ins[6:0] == 7'b1000011 || ins[6:0] == 7'b1000111 ||
               ins[6:0] == 7'b1001011 || ins[6:0] == 7'b1001111;
    endfunction

    function automatic bit m_writes_f(input logic [31:0] ins);
        if (ins[6:0] == 7'b0000111 || m_fused(ins)) return 1'b1;
        if (ins[6:0] == 7'b1010011)
            return !(ins[31:25] == 7'b1110000 || ins[31:25] == 7'b1010000 ||
                     ins[31:25] == 7'b1100000);
        return 1'b0;
    endfunction

    typedef struct {
        int         t;
        logic [4:0] rd;
    } wr_t;

    wr_t         q[$];
    int          m_cyc;
    bit          m_full;
    bit          m_drain;
    logic [31:0] m_hold;
    logic [15:0] m_stall;

    // A write issued at enabled-cycle t is in flight for ages 1..PS and blocks readers for ages 1..PS-1.
    function automatic bit m_blocks(input logic [31:0] ins);
        for (int i = 0; i < q.size(); i++) begin
            int age;
            age = m_cyc - q[i].t;
            if (age >= 1 && age <= PS - 1 &&
                (q[i].rd == ins[19:15] || q[i].rd == ins[24:20] ||
                 (m_fused(ins) && q[i].rd == ins[31:27])))
                return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic bit m_inflight();
        for (int i = 0; i < q.size(); i++) begin
            if (m_cyc - q[i].t >= 1 && m_cyc - q[i].t <= PS) return 1'b1;
        end
        return 1'b0;
    endfunction

    initial begin : compare
        bit  haz, iss, rdy, bsy;
        wr_t w;
        m_cyc = 0; m_full = 0; m_drain = 0; m_hold = '0; m_stall = '0;
        forever begin
            @(negedge ck);
            if (!rst_n) begin
                chk("rst_issue_valid", {31'b0, issue_valid}, 32'd0);
                chk("rst_instr_ready", {31'b0, instr_ready}, 32'd0);
                chk("rst_busy", {31'b0, busy}, 32'd0);
                chk("rst_stall_cnt", {16'b0, stall_cnt}, 32'd0);
                q.delete();
                m_cyc = 0; m_full = 0; m_drain = 0; m_hold = '0; m_stall = '0;
            end else begin
                haz = m_full && m_blocks(m_hold);
                iss = enable && m_full && !haz && !flush;
                rdy = enable && !m_drain && (!m_full || iss);
                bsy = m_full || m_drain || m_inflight();
                chk("issue_valid", {31'b0, issue_valid}, {31'b0, iss});
                if (iss) chk("issue_instr", issue_instr, m_hold);
                chk("instr_ready", {31'b0, instr_ready}, {31'b0, rdy});
                chk("busy", {31'b0, busy}, {31'b0, bsy});
                chk("stall_cnt", {16'b0, stall_cnt}, {16'b0, m_stall});
                if (enable) begin
`ifdef RVFPM_ISSUE_STALL_CNT_EN
                    if (haz && m_stall != 16'hFFFF) m_stall = m_stall + 16'd1;
`endif
                    if (iss && m_writes_f(m_hold)) begin
                        w.t  = m_cyc;
                        w.rd = m_hold[11:7];
                        q.push_back(w);
                    end
                    if (flush) begin
                        m_full  = 0;
                        m_drain = 1;
                    end else if (m_drain) begin
                        if (!m_inflight()) m_drain = 0;
                    end else if (instr_valid && rdy) begin
                        m_hold = instruction;
                        m_full = 1;
                    end else if (iss) begin
                        m_full = 0;
                    end
                    m_cyc++;
                    while (q.size() > 0 && m_cyc - q[0].t > PS) void'(q.pop_front());
                end
            end
        end
    end

    // ---------------- directed sequence driver ----------------
    logic [31:0] seq [8];
    int          seq_n;
    int          iss_cyc [8];
    logic [31:0] iss_ins [8];
    int          n_iss;
    logic        rdy_log [32];
    logic        busy_log [32];

    task automatic run_seq(input int ncyc, input int flush_at);
        int idx;
        idx   = 0;
        n_iss = 0;
        for (int k = 0; k < ncyc; k++) begin
            instr_valid = (idx < seq_n);
            instruction = (idx < seq_n) ? seq[idx] : 32'h0;
            flush       = (k == flush_at);
            @(negedge ck);
            rdy_log[k]  = instr_ready;
            busy_log[k] = busy;
            if (issue_valid && n_iss < 8) begin
                iss_cyc[n_iss] = k;
                iss_ins[n_iss] = issue_instr;
                n_iss++;
            end
            if (instr_valid && instr_ready) idx++;
            @(posedge ck);
            #1;
        end
        instr_valid = 1'b0;
        instruction = '0;
        flush       = 1'b0;
    endtask

    task automatic apply_reset();
        instr_valid = 1'b0;
        flush       = 1'b0;
        enable      = 1'b1;
        rst_n       = 1'b0;
        repeat (2) @(posedge ck);
        #1;
        rst_n = 1'b1;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        logic [1:0]  k;
        w        = $urandom;
        w[11:7]  = 5'($urandom_range(0, 7));
        w[19:15] = 5'($urandom_range(0, 7));
        w[24:20] = 5'($urandom_range(0, 7));
        k        = 2'($urandom_range(0, 3));
        case ($urandom_range(0, 5))
            0: w[6:0] = 7'b0000111;
            1: begin
                w[6:0]   = {3'b100, k, 2'b11};
                w[31:27] = 5'($urandom_range(0, 7));
            end
            2, 3: begin
                w[6:0] = 7'b1010011;
                case ($urandom_range(0, 5))
                    0: w[31:25] = 7'b0000000;
                    1: w[31:25] = 7'b0001000;
                    2: w[31:25] = 7'b1110000;
                    3: w[31:25] = 7'b1010000;
                    4: w[31:25] = 7'b1100000;
                    default: w[31:25] = 7'b0101100;
                endcase
            end
            4: w[6:0] = 7'b0100111;
            default: ;
        endcase
        return w;
    endfunction

    localparam logic [15:0] EXP_STALL3 =
`ifdef RVFPM_ISSUE_STALL_CNT_EN
        16'd3;
`else
        16'd0;
`endif

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stim
        logic [31:0] fadd3;
        fadd3 = fp_r(7'b0000000, 5'd2, 5'd1, 5'd3);

        #3;
        chk("por_issue_instr", issue_instr, 32'd0);
        chk("por_instr_ready", {31'b0, instr_ready}, 32'd0);
        apply_reset();

        // single FADD: accept at 0, issue at 1, busy through cycle 5
        seq[0] = fadd3; seq_n = 1;
        run_seq(8, -1);
        chk("t1_ready_c0", {31'b0, rdy_log[0]}, 32'd1);
        chk("t1_n_issue", n_iss, 1);
        chk("t1_issue_cyc", iss_cyc[0], 1);
        chk("t1_issue_instr", iss_ins[0], fadd3);
        chk("t1_busy_c0", {31'b0, busy_log[0]}, 32'd0);
        for (int c = 1; c <= 5; c++) chk("t1_busy_on", {31'b0, busy_log[c]}, 32'd1);
        chk("t1_busy_c6", {31'b0, busy_log[6]}, 32'd0);

        // RAW on rs1: FMUL waits for FADD
        apply_reset();
        seq[0] = fadd3; seq[1] = fp_r(7'b0001000, 5'd5, 5'd3, 5'd4); seq_n = 2;
        run_seq(10, -1);
        chk("t2_n_issue", n_iss, 2);
        chk("t2_fadd_cyc", iss_cyc[0], 1);
        chk("t2_fmul_cyc", iss_cyc[1], 5);
        chk("t2_fmul_instr", iss_ins[1], seq[1]);
        chk("t2_stall_cnt", {16'b0, stall_cnt}, {16'b0, EXP_STALL3});

        // FMV.X.W does not claim an F destination
        apply_reset();
        seq[0] = fp_r(7'b1110000, 5'd0, 5'd3, 5'd5); seq[1] = fp_r(7'b0000000, 5'd5, 5'd5, 5'd6);
        seq_n = 2;
        run_seq(6, -1);
        chk("t3_n_issue", n_iss, 2);
        chk("t3_first_cyc", iss_cyc[0], 1);
        chk("t3_second_cyc", iss_cyc[1], 2);
        chk("t3_stall_cnt", {16'b0, stall_cnt}, 32'd0);

        // rs3-only hazard on fused op
        apply_reset();
        seq[0] = fadd3; seq[1] = fmadd(5'd3, 5'd2, 5'd1, 5'd7); seq_n = 2;
        run_seq(10, -1);
        chk("t4_n_issue", n_iss, 2);
        chk("t4_fmadd_cyc", iss_cyc[1], 5);
        chk("t4_stall_cnt", {16'b0, stall_cnt}, {16'b0, EXP_STALL3});

        // flush on hazard cycle: FMUL dropped, drain until FADD retires
        apply_reset();
        seq[0] = fadd3; seq[1] = fp_r(7'b0001000, 5'd5, 5'd3, 5'd4); seq_n = 2;
        run_seq(9, 2);
        chk("t5_n_issue", n_iss, 1);
        for (int c = 3; c <= 6; c++) chk("t5_ready_drain", {31'b0, rdy_log[c]}, 32'd0);
        chk("t5_ready_idle", {31'b0, rdy_log[7]}, 32'd1);
        chk("t5_busy_idle", {31'b0, busy_log[7]}, 32'd0);

        // reset asserted mid-stall
        apply_reset();
        seq[0] = fadd3; seq[1] = fp_r(7'b0001000, 5'd5, 5'd3, 5'd4); seq_n = 2;
        run_seq(3, -1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_issue_valid", {31'b0, issue_valid}, 32'd0);
        chk("t6_issue_instr", issue_instr, 32'd0);
        chk("t6_instr_ready", {31'b0, instr_ready}, 32'd0);
        chk("t6_busy", {31'b0, busy}, 32'd0);
        chk("t6_stall_cnt", {16'b0, stall_cnt}, 32'd0);
        @(posedge ck);
        #1;
        rst_n = 1'b1;
        seq_n = 0;
        run_seq(10, -1);
        chk("t6_no_issue", n_iss, 0);

        // randomized traffic against the model
        for (int c = 0; c < 4000; c++) begin
            enable      = ($urandom_range(0, 9) != 0);
            instr_valid = ($urandom_range(0, 2) != 0);
            instruction = rand_instr();
            flush       = ($urandom_range(0, 39) == 0);
            @(posedge ck);
            #1;
        end
        instr_valid = 1'b0;
        flush       = 1'b0;
        enable      = 1'b1;
        repeat (10) @(posedge ck);
        #1;
        chk("final_busy", {31'b0, busy}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
